// File: rtl/float_encode_pipe.sv
// float_encode_pipe
//   Three-stage pipelined converter from an IN_W-bit two's-complement sample
//   to a compact float {sign, EXP_W exponent, MANT_W mantissa}.
//     S1: sign / magnitude / most-negative flag
//     S2: leading-zero count of the magnitude
//     S3: normalise, round (optional), saturate -> registered outputs
//   The whole pipe stalls together when the output is held (no bubble collapsing).
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake (in_ready is combinational)
//   in_data  [IN_W-1:0]     two's-complement sample
//   out_valid/out_ready     output handshake
//   out_sign, out_exp [EXP_W-1:0], out_mant [MANT_W-1:0]   result fields
//
// Build option
//   FLOAT_ENC_ROUND_EN  defined: round-to-nearest using the first dropped bit,
//                       with carry into the exponent and saturation at the top.
//                       undefined: plain truncation.
//
// Parameter constraints: IN_W >= MANT_W+2, IN_W-MANT_W <= 2**EXP_W.

module float_encode_pipe #(
    parameter int IN_W   = 12,
    parameter int MANT_W = 4,
    parameter int EXP_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant
);

    localparam int STAGES = 3;
    localparam int E0     = IN_W - MANT_W;
    localparam int EMAX   = (1 << EXP_W) - 1;
    localparam int LZ_W   = $clog2(IN_W + 1);
    // one spare bit so E0 (which may equal 2**EXP_W) and the carry fit
    localparam int EW     = EXP_W + 1;
    localparam int MW1    = MANT_W + 1;

`ifdef FLOAT_ENC_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    // ---------------------------------------------------------------
    // flow control: global stall, valid bits shift only on advance
    // ---------------------------------------------------------------
    logic [STAGES:1] vld_pipe;
    logic            adv;

    assign adv       = out_ready | ~vld_pipe[STAGES];
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // leading zeros over IN_W bits; all-zero input yields IN_W
    function automatic logic [LZ_W-1:0] clz(input logic [IN_W-1:0] v);
        clz = LZ_W'(IN_W);
        for (int i = 0; i < IN_W; i++)
            if (v[i]) clz = LZ_W'(IN_W - 1 - i);
    endfunction

    // ---------------------------------------------------------------
    // S1: sign / magnitude
    // ---------------------------------------------------------------
    logic              s1_sign, s1_minneg;
    logic [IN_W-1:0]   s1_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign   <= 1'b0;
            s1_minneg <= 1'b0;
            s1_mag    <= '0;
        end else if (adv) begin
            s1_sign   <= in_data[IN_W-1];
            // -2**(IN_W-1) negates to itself; flagged and forced later
            s1_minneg <= (in_data == {1'b1, {(IN_W-1){1'b0}}});
            s1_mag    <= in_data[IN_W-1] ? -in_data : in_data;
        end
    end

    // ---------------------------------------------------------------
    // S2: leading-zero count
    // ---------------------------------------------------------------
    logic              s2_sign, s2_minneg;
    logic [IN_W-1:0]   s2_mag;
    logic [LZ_W-1:0]   s2_lz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign   <= 1'b0;
            s2_minneg <= 1'b0;
            s2_mag    <= '0;
            s2_lz     <= '0;
        end else if (adv) begin
            s2_sign   <= s1_sign;
            s2_minneg <= s1_minneg;
            s2_mag    <= s1_mag;
            s2_lz     <= clz(s1_mag);
        end
    end

    // ---------------------------------------------------------------
    // S3: extract, round, saturate
    // ---------------------------------------------------------------
    logic              s3_sign;
    logic [EW-1:0]     e_x;
    logic [MANT_W-1:0] m_x;
    logic [MW1-1:0]    top;    // {mantissa, round bit} after normalisation
    logic [MW1-1:0]    m_inc;
    logic              rb;

    always_comb begin
        s3_sign = s2_sign;
        top     = MW1'((s2_mag << s2_lz) >> (IN_W - 1 - MANT_W));
        e_x     = '0;
        m_x     = '0;
        rb      = 1'b0;
        m_inc   = '0;

        if (s2_lz >= LZ_W'(E0)) begin
            // too small to normalise: raw low bits, exponent 0
            m_x = s2_mag[MANT_W-1:0];
        end else begin
            m_x = top[MANT_W:1];
            rb  = top[0];
            e_x = EW'(E0) - EW'(s2_lz);
        end

        if (e_x > EW'(EMAX)) begin
            e_x = EW'(EMAX);
            m_x = '1;
        end

        if (ROUND_EN && rb) begin
            m_inc = {1'b0, m_x} + MW1'(1);
            if (m_inc[MANT_W]) begin
                if (e_x == EW'(EMAX)) begin
                    m_x = '1;
                end else begin
                    m_x           = '0;
                    m_x[MANT_W-1] = 1'b1;
                    e_x           = e_x + EW'(1);
                end
            end else begin
                m_x = m_inc[MANT_W-1:0];
            end
        end

        if (s2_minneg) begin
            s3_sign = 1'b1;
            e_x     = EW'(EMAX);
            m_x     = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_mant <= '0;
        end else if (adv) begin
            out_sign <= s3_sign;
            out_exp  <= e_x[EXP_W-1:0];
            out_mant <= m_x;
        end
    end

endmodule
